// File: rtl/eth_udp_pkg.sv
// Shared types and constants for the UDP stream controller.
package eth_udp_pkg;

  typedef enum logic [3:0] {
    ST_BOOT,
    ST_ARP_REQ,
    ST_ARP_SEND,
    ST_ARP_WAIT,
    ST_READY,
    ST_CHECK_ARP,
    ST_GEN_REQ,
    ST_WRITE,
    ST_SEND
  } state_e;

  localparam int unsigned HB_LEN          = 4;
  localparam int unsigned UDP_MAX_PAYLOAD = 1472;

  // Heartbeat payload is the sequence number, most significant byte first.
  function automatic logic [7:0] hb_byte(input logic [31:0] seq, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = seq[31:24];
      2'd1:    b = seq[23:16];
      2'd2:    b = seq[15:8];
      default: b = seq[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/eth_udp_frame_buf.sv
// Simple dual-port byte RAM holding one payload frame; registered read port.
module eth_udp_frame_buf #(
  parameter int unsigned DEPTH = 1472,
  parameter int unsigned AW    = 11
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/eth_udp_stream_ctrl.sv
// Byte-stream UDP application controller: buffers one frame, resolves the peer via ARP
// with bounded retries, and hands the frame (or an idle heartbeat) to udp_ip_mac_top.
module eth_udp_stream_ctrl
  import eth_udp_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD   = UDP_MAX_PAYLOAD,
  parameter int unsigned TIMER_CYCLES  = 125_000_000,
  parameter int unsigned ARP_RETRY_MAX = 4,
  parameter bit          HB_EN         = 1'b0
) (
  input  logic        rgmii_clk,
  input  logic        rst,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic        app_data_request,
  output logic [15:0] app_data_length,
  output logic        app_data_in_valid,
  output logic [7:0]  app_data_in,
  input  logic        udp_send_ack,
  output logic        arp_req,
  input  logic        arp_found,
  input  logic        mac_not_exist,
  input  logic        mac_send_end,
  output logic        tx_done,
  output logic        ovf_err,
  output logic        arp_fail
);

  localparam int unsigned AW        = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [15:0] MAX_LEN   = 16'(MAX_PAYLOAD);
  localparam logic [31:0] TMR_LAST  = 32'(TIMER_CYCLES - 1);
  localparam logic [15:0] RETRY_MAX = 16'(ARP_RETRY_MAX);
  localparam logic [15:0] HB_LEN16  = 16'(HB_LEN);

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [15:0] retry_q, retry_d;
  logic        arp_fail_q, arp_fail_d;
  logic        hb_sel_q, hb_sel_d;
  logic [15:0] len_q, len_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] seq_q, seq_d;
  logic        tx_done_q, tx_done_d;

  logic [15:0] wr_len_q;
  logic        frame_done_q, frame_done_d;
  logic        s_ready_q;
  logic        ovf_q;

  logic          tmr_hit;
  logic          accept;
  logic          wr_en;
  logic          buf_drain;
  logic [15:0]   rd_next;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;

  assign tmr_hit = (timer_q == TMR_LAST);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + 32'd1;
    retry_d    = retry_q;
    arp_fail_d = arp_fail_q;
    hb_sel_d   = hb_sel_q;
    len_d      = len_q;
    rd_cnt_d   = rd_cnt_q;
    seq_d      = seq_q;
    tx_done_d  = 1'b0;
    unique case (state_q)
      ST_BOOT:     if (tmr_hit) state_d = ST_ARP_REQ;
      ST_ARP_REQ:  state_d = ST_ARP_SEND;
      ST_ARP_SEND: if (mac_send_end) state_d = ST_ARP_WAIT;
      ST_ARP_WAIT: begin
        if (arp_found) begin
          state_d = ST_READY;
        end else if (tmr_hit) begin
          state_d = ST_ARP_REQ;
          if (retry_q < RETRY_MAX) retry_d = retry_q + 16'd1;
          if (retry_q + 16'd1 >= RETRY_MAX) arp_fail_d = 1'b1;
        end
      end
      ST_READY: begin
        if (frame_done_q) begin
          state_d  = ST_CHECK_ARP;
          hb_sel_d = 1'b0;
        end else if (HB_EN && tmr_hit) begin
          state_d  = ST_CHECK_ARP;
          hb_sel_d = 1'b1;
        end
      end
      ST_CHECK_ARP: begin
        if (mac_not_exist) begin
          state_d = ST_ARP_REQ;
        end else begin
          state_d = ST_GEN_REQ;
          len_d   = hb_sel_q ? HB_LEN16 : wr_len_q;
        end
      end
      ST_GEN_REQ: begin
        rd_cnt_d = '0;
        if (udp_send_ack) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        rd_cnt_d = rd_cnt_q + 16'd1;
        if (rd_cnt_q == len_q - 16'd1) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (mac_send_end) begin
          state_d   = ST_READY;
          tx_done_d = 1'b1;
          if (hb_sel_q) seq_d = seq_q + 32'd1;
        end
      end
      default: state_d = ST_BOOT;
    endcase
    if (arp_found) begin
      retry_d    = '0;
      arp_fail_d = 1'b0;
    end
    if ((state_d != state_q) || !(state_q inside {ST_BOOT, ST_ARP_WAIT, ST_READY})) begin
      timer_d = '0;
    end
  end

  always_ff @(posedge rgmii_clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      timer_q    <= '0;
      retry_q    <= '0;
      arp_fail_q <= 1'b0;
      hb_sel_q   <= 1'b0;
      len_q      <= '0;
      rd_cnt_q   <= '0;
      seq_q      <= '0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      retry_q    <= retry_d;
      arp_fail_q <= arp_fail_d;
      hb_sel_q   <= hb_sel_d;
      len_q      <= len_d;
      rd_cnt_q   <= rd_cnt_d;
      seq_q      <= seq_d;
      tx_done_q  <= tx_done_d;
    end
  end

  // Ingest: overflow bytes are accepted but not stored; wr_len_q doubles as frame length.
  assign accept    = s_valid && s_ready_q;
  assign wr_en     = accept && (wr_len_q < MAX_LEN);
  assign buf_drain = (state_q == ST_WRITE) && (state_d != ST_WRITE) && !hb_sel_q;

  always_comb begin
    frame_done_d = frame_done_q;
    if (buf_drain) begin
      frame_done_d = 1'b0;
    end else if (accept && s_last) begin
      frame_done_d = 1'b1;
    end
  end

  always_ff @(posedge rgmii_clk) begin
    if (rst) begin
      wr_len_q     <= '0;
      frame_done_q <= 1'b0;
      s_ready_q    <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      frame_done_q <= frame_done_d;
      s_ready_q    <= !frame_done_d;
      ovf_q        <= accept && s_last && (wr_len_q >= MAX_LEN);
      if (buf_drain) begin
        wr_len_q <= '0;
      end else if (wr_en) begin
        wr_len_q <= wr_len_q + 16'd1;
      end
    end
  end

  // Byte 0 is read during GEN_REQ so WRITE streams without a bubble.
  assign rd_next = rd_cnt_q + 16'd1;
  assign rd_addr = ((state_q == ST_WRITE) && (rd_next < MAX_LEN)) ? rd_next[AW-1:0] : '0;

  eth_udp_frame_buf #(
    .DEPTH (MAX_PAYLOAD),
    .AW    (AW)
  ) u_frame_buf (
    .clk_i   (rgmii_clk),
    .we_i    (wr_en),
    .waddr_i (wr_len_q[AW-1:0]),
    .wdata_i (s_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign s_ready           = s_ready_q;
  assign arp_req           = (state_q == ST_ARP_REQ);
  assign app_data_request  = (state_q == ST_GEN_REQ);
  assign app_data_in_valid = (state_q == ST_WRITE);
  assign app_data_in       = (state_q != ST_WRITE) ? 8'h00 :
                             hb_sel_q ? hb_byte(seq_q, rd_cnt_q[1:0]) : rd_data;
  assign app_data_length   = len_q;
  assign tx_done           = tx_done_q;
  assign ovf_err           = ovf_q;
  assign arp_fail          = arp_fail_q;

endmodule
